// File: rtl/axis_master_out.sv
// axis_master_out: AXI4-Stream transmit end of the accelerator.
// Result words from the output packers (no backpressure) are buffered in a
// circular FIFO of {last, data} entries and presented on M_AXIS_* through a
// single output register with a full TVALID/TREADY handshake.
// Build option: define AXIS_TX_STORE_FORWARD_EN to hold a frame back until
// its last word is buffered (or the FIFO fills); default is cut-through.
//
// state | meaning
// ------+-----------------------------------------------------
// IDLE  | output register empty, TVALID low
// SEND  | output register holds a beat, TVALID high until taken
module axis_master_out #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_SIZE            = 16,
  parameter int BIT_NUM              = $clog2(FIFO_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   in_data,
  input  logic                              in_last,
  input  logic                              axis_en,
  input  logic                              axis_clear,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [BIT_NUM:0]                  fifo_cnt,
  output logic                              fifo_full,
  output logic                              fifo_empty,
  output logic                              overflow,
  output logic                              frame_done
);

  localparam int W = C_M_AXIS_TDATA_WIDTH;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [W:0]         mem_q [FIFO_SIZE];
  logic [BIT_NUM-1:0] wr_ptr_q, rd_ptr_q;
  logic [BIT_NUM:0]   cnt_q, cnt_d;
  logic [W-1:0]       data_q;
  logic               last_q;
  logic               overflow_q;
  logic               frame_done_q;

  logic               write, load, handshake, tvalid, sf_ok;
  logic [W:0]         head;

  assign tvalid     = (state_q == SEND);
  assign fifo_full  = (cnt_q == (BIT_NUM+1)'(FIFO_SIZE));
  assign fifo_empty = (cnt_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // fifo_full is the registered count, so a same-cycle pop never admits a write
  assign write     = in_valid & axis_en & ~fifo_full;
  assign handshake = tvalid & M_AXIS_TREADY;
  assign load      = axis_en & ~fifo_empty & (~tvalid | M_AXIS_TREADY) & sf_ok;
  assign cnt_d     = cnt_q + (BIT_NUM+1)'(write) - (BIT_NUM+1)'(load);

`ifdef AXIS_TX_STORE_FORWARD_EN
  logic [BIT_NUM:0] last_cnt_q;
  logic             frame_open_q;

  assign sf_ok = (last_cnt_q != '0) | fifo_full | frame_open_q;

  // Count buffered frame ends; track whether a frame has started streaming
  always_ff @(posedge clk) begin
    if (rst | axis_clear) begin
      last_cnt_q   <= '0;
      frame_open_q <= 1'b0;
    end else begin
      last_cnt_q <= last_cnt_q + (BIT_NUM+1)'(write & in_last)
                               - (BIT_NUM+1)'(load & head[W]);
      if (load) frame_open_q <= ~head[W];
    end
  end
`else
  assign sf_ok = 1'b1;
`endif

  // FIFO storage; entries need no reset since the count qualifies them
  always_ff @(posedge clk) begin
    if (write) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  // Pointers, count, output register and status flags
  always_ff @(posedge clk) begin
    if (rst | axis_clear) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= head[W-1:0];
        last_q   <= head[W];
      end
      cnt_q <= cnt_d;
      if (in_valid & axis_en & fifo_full) overflow_q <= 1'b1;
      frame_done_q <= handshake & last_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst | axis_clear) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // FSM next state: a beat is held until taken, refilled back-to-back on load
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SEND;
      SEND:    if (handshake) state_d = load ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = data_q;
  assign M_AXIS_TLAST  = last_q;
  assign M_AXIS_TSTRB  = '1;
  assign fifo_cnt      = cnt_q;
  assign overflow      = overflow_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_axis_master_out.sv
// Bench for axis_master_out: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_axis_master_out;

  localparam int W  = 32;
  localparam int FS = 16;
  localparam int BN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, axis_en = 1'b0, axis_clear = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          tready = 1'b0;
  logic          tvalid, tlast, full, empty, ovf, fdone;
  logic [W-1:0]  tdata;
  logic [W/8-1:0] tstrb;
  logic [BN:0]   cnt;

  axis_master_out #(.C_M_AXIS_TDATA_WIDTH(W), .FIFO_SIZE(FS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .axis_en(axis_en), .axis_clear(axis_clear),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready), .fifo_cnt(cnt),
    .fifo_full(full), .fifo_empty(empty), .overflow(ovf), .frame_done(fdone)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue plus the presented beat
  logic [W:0]   m_q[$];
  logic         m_tv, m_last, m_ovf, m_fd, m_open;
  logic [W-1:0] m_data;

  task automatic model_reset();
    m_q.delete();
    m_tv = 0; m_last = 0; m_ovf = 0; m_fd = 0; m_open = 0; m_data = '0;
  endtask

  task automatic model_step();
    bit full_n, wr, ld, hs, sf;
    int lasts;
    logic [W:0] e;
    if (rst || axis_clear) begin
      model_reset();
      return;
    end
    full_n = (m_q.size() == FS);
    wr = in_valid && axis_en && !full_n;
    if (in_valid && axis_en && full_n) m_ovf = 1;
    lasts = 0;
    foreach (m_q[i]) if (m_q[i][W]) lasts++;
`ifdef AXIS_TX_STORE_FORWARD_EN
    sf = (lasts > 0) || full_n || m_open;
`else
    sf = 1;
`endif
    ld = axis_en && (m_q.size() > 0) && (!m_tv || tready) && sf;
    hs = m_tv && tready;
    m_fd = hs && m_last;
    if (ld) begin
      e = m_q.pop_front();
      m_data = e[W-1:0]; m_last = e[W]; m_tv = 1; m_open = !e[W];
    end else if (hs) m_tv = 0;
    if (wr) m_q.push_back({in_last, in_data});
  endtask

  // Values sampled during the most recent step, and accepted beats
  logic         s_tv, s_last, s_full, s_ovf, s_fd;
  logic [W-1:0] s_data;
  logic [BN:0]  s_cnt;
  logic [W-1:0] rx[$];
  int           fd_count = 0;

  task automatic step(input bit v, input logic [W-1:0] d, input bit l,
                      input bit en, input bit clr, input bit rdy);
    in_valid = v; in_data = d; in_last = l; axis_en = en; axis_clear = clr; tready = rdy;
    @(negedge clk);
    s_tv = tvalid; s_data = tdata; s_last = tlast; s_cnt = cnt;
    s_full = full; s_ovf = ovf; s_fd = fdone;
    if (tvalid && tready) rx.push_back(tdata);
    if (fdone) fd_count++;
    chk("tvalid", tvalid, m_tv);
    chk("tdata", tdata, m_data);
    chk("tlast", tlast, m_last);
    chk("fifo_cnt", cnt, m_q.size());
    chk("fifo_full", full, m_q.size() == FS);
    chk("fifo_empty", empty, m_q.size() == 0);
    chk("overflow", ovf, m_ovf);
    chk("frame_done", fdone, m_fd);
    chk("tstrb", tstrb, 4'hF);
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; axis_clear = 0; tready = 0; axis_en = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    rx.delete();
    fd_count = 0;
  endtask

  typedef struct {
    bit v; logic [W-1:0] d; bit l; bit rdy;
    bit e_tv; logic [W-1:0] e_data; bit e_last; int e_cnt; bit e_fd;
  } vec_t;

  vec_t vt[8];
  int   first_rise;
  int   exp_rise;

  initial begin
    vt[0] = '{1, 32'h11, 0, 1,  0, 32'h00, 0, 0, 0};
    vt[1] = '{1, 32'h22, 0, 1,  0, 32'h00, 0, 1, 0};
    vt[2] = '{1, 32'h33, 0, 1,  1, 32'h11, 0, 1, 0};
    vt[3] = '{1, 32'h44, 1, 1,  1, 32'h22, 0, 1, 0};
    vt[4] = '{0, 32'h00, 0, 1,  1, 32'h33, 0, 1, 0};
    vt[5] = '{0, 32'h00, 0, 1,  1, 32'h44, 1, 0, 0};
    vt[6] = '{0, 32'h00, 0, 1,  0, 32'h44, 1, 0, 1};
    vt[7] = '{0, 32'h00, 0, 1,  0, 32'h44, 1, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state and four-word frame with TREADY held high
    for (int i = 0; i < 8; i++) begin
      step(vt[i].v, vt[i].d, vt[i].l, 1, 0, vt[i].rdy);
      chk($sformatf("vec%0d tvalid", i), s_tv, vt[i].e_tv);
      chk($sformatf("vec%0d tdata", i), s_data, vt[i].e_data);
      chk($sformatf("vec%0d tlast", i), s_last, vt[i].e_last);
      chk($sformatf("vec%0d cnt", i), s_cnt, vt[i].e_cnt);
      chk($sformatf("vec%0d frame_done", i), s_fd, vt[i].e_fd);
    end
    chk("frame1 frame_done count", fd_count, 1);
    chk("frame1 empty at end", empty, 1);

    // Backpressure: beat held stable for 10 cycles, then drained in order
    do_reset();
    step(1, 32'h11, 0, 1, 0, 0);
    step(1, 32'h22, 0, 1, 0, 0);
    step(1, 32'h33, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("stall tvalid", s_tv, 1);
      chk("stall tdata", s_data, 32'h11);
      chk("stall cnt", s_cnt, 2);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 1);
    chk("stall rx size", rx.size(), 3);
    if (rx.size() == 3) begin
      chk("stall rx0", rx[0], 32'h11);
      chk("stall rx1", rx[1], 32'h22);
      chk("stall rx2", rx[2], 32'h33);
    end
    chk("stall tvalid after drain", s_tv, 0);

    // Overflow: 20 words into a stalled FIFO, then a dropped write during a pop
    do_reset();
    for (int i = 1; i <= 20; i++) step(1, i, i == 20, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("ovf full", s_full, 1);
    chk("ovf cnt", s_cnt, 16);
    chk("ovf flag", s_ovf, 1);
    step(1, 32'h99, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("full+pop cnt", s_cnt, 15);
    chk("full+pop ovf", s_ovf, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 1);
    chk("ovf rx size", rx.size(), 17);
    for (int i = 0; i < rx.size() && i < 17; i++) chk($sformatf("ovf rx%0d", i), rx[i], i + 1);
    chk("ovf sticky", s_ovf, 1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("ovf cleared", s_ovf, 0);

    // Flush mid-frame, then a clean two-word frame
    do_reset();
    for (int i = 1; i <= 10; i++) step(1, 32'h100 + i, i == 10, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("pre-clear tvalid", s_tv, 1);
    step(0, 0, 0, 1, 1, 0);
    rx.delete();
    fd_count = 0;
    step(0, 0, 0, 1, 0, 1);
    chk("clear tvalid", s_tv, 0);
    chk("clear cnt", s_cnt, 0);
    chk("clear ovf", s_ovf, 0);
    step(1, 32'hA1, 0, 1, 0, 1);
    step(1, 32'hA2, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 1);
    chk("post-clear rx size", rx.size(), 2);
    if (rx.size() == 2) begin
      chk("post-clear rx0", rx[0], 32'hA1);
      chk("post-clear rx1", rx[1], 32'hA2);
    end
    chk("post-clear frame_done count", fd_count, 1);

    // Frame start timing: three plain words, last word eight cycles later
    do_reset();
    first_rise = -1;
    for (int c = 0; c < 16; c++) begin
      if (c < 3)       step(1, 32'h200 + c, 0, 1, 0, 1);
      else if (c == 10) step(1, 32'h2FF, 1, 1, 0, 1);
      else             step(0, 0, 0, 1, 0, 1);
      if (s_tv && first_rise < 0) first_rise = c;
    end
`ifdef AXIS_TX_STORE_FORWARD_EN
    exp_rise = 12;
`else
    exp_rise = 2;
`endif
    chk("first tvalid cycle", first_rise, exp_rise);
    chk("sf rx size", rx.size(), 4);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
